// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: ROM geometry and requester port indices.
package cpu_pkg;

    localparam int unsigned ROM_ADDR_W = 6;
    localparam int unsigned INSTR_W    = 32;

    typedef logic port_idx_t;

    localparam port_idx_t PORT_FETCH = 1'b0;
    localparam port_idx_t PORT_DBG   = 1'b1;

endpackage : cpu_pkg

// File: rtl/rr_arbiter2.sv
// Two-requester grant logic with optional round-robin priority rotation.
module rr_arbiter2
    import cpu_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] i_req_valid,
    output logic [1:0] o_grant_c
);

    port_idx_t r_prio;

    // Combinational one-hot grant; nothing is granted while reset is held.
    always_comb begin
        o_grant_c = 2'b00;
        if (!reset) begin
            if (i_req_valid == 2'b11) begin
                if (FIXED_PRIO != 0 || r_prio == PORT_FETCH) begin
                    o_grant_c = 2'b01;
                end else begin
                    o_grant_c = 2'b10;
                end
            end else begin
                o_grant_c = i_req_valid;
            end
        end
    end

    // After an accept the other port becomes the preferred one.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prio <= PORT_FETCH;
        end else if (o_grant_c[0]) begin
            r_prio <= PORT_DBG;
        end else if (o_grant_c[1]) begin
            r_prio <= PORT_FETCH;
        end
    end

endmodule : rr_arbiter2

// File: rtl/rom_fetch_arbiter.sv
// Shares the single-port instruction ROM between CPU fetch and debug reader;
// returns the ROM word to the winner one cycle after acceptance.
module rom_fetch_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = ROM_ADDR_W,
    parameter int unsigned DATA_W     = INSTR_W,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_instruction
);

    logic [1:0]        w_grant;
    logic              w_accept;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_pend;
    port_idx_t         r_sel;

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clock       (clock),
        .reset       (reset),
        .i_req_valid ({req1_valid, req0_valid}),
        .o_grant_c   (w_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign w_accept   = |w_grant;

    // ROM address follows the winner; when idle it holds the last read so the ROM output stays stable.
    always_comb begin
        rom_address = r_last_addr;
        if (reset) begin
            rom_address = '0;
        end else if (w_grant[0]) begin
            rom_address = req0_addr;
        end else if (w_grant[1]) begin
            rom_address = req1_addr;
        end
    end

    // Track the outstanding read so the response lands on the right port next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_addr <= '0;
            r_pend      <= 1'b0;
            r_sel       <= PORT_FETCH;
        end else begin
            r_pend <= w_accept;
            if (w_accept) begin
                r_last_addr <= rom_address;
                r_sel       <= port_idx_t'(w_grant[1]);
            end
        end
    end

    // Route the ROM word to the requester whose read completes this cycle; a reset drops it.
    always_comb begin
        rsp0_valid = !reset && r_pend && (r_sel == PORT_FETCH);
        rsp1_valid = !reset && r_pend && (r_sel == PORT_DBG);
        rsp0_data  = rsp0_valid ? rom_instruction : '0;
        rsp1_data  = rsp1_valid ? rom_instruction : '0;
    end

endmodule : rom_fetch_arbiter

// File: tb/tb_rom_fetch_arbiter.sv
// Bench for rom_fetch_arbiter: round-robin instance driven from a vector
// table, fixed-priority instance driven by a hand-written contention sequence.
module tb_rom_fetch_arbiter;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- round-robin DUT ----------------
    logic          reset, v0, v1, rdy0, rdy1, rsp0v, rsp1v;
    logic [AW-1:0] a0, a1, rom_addr;
    logic [DW-1:0] rsp0d, rsp1d, rom_data;
    logic [AW-1:0] rom_reg;

    rom_fetch_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut_rr (
        .clock(clock), .reset(reset),
        .req0_valid(v0), .req0_addr(a0), .req0_ready(rdy0),
        .rsp0_valid(rsp0v), .rsp0_data(rsp0d),
        .req1_valid(v1), .req1_addr(a1), .req1_ready(rdy1),
        .rsp1_valid(rsp1v), .rsp1_data(rsp1d),
        .rom_address(rom_addr), .rom_instruction(rom_data)
    );

    // ROM model: registered address, unregistered data, word[i] = A000_0000 + i
    always @(posedge clock) rom_reg <= rom_addr;
    assign rom_data = 32'hA000_0000 + DW'(rom_reg);

    // ---------------- fixed-priority DUT ----------------
    logic          f_reset, f_v0, f_v1, f_rdy0, f_rdy1, f_rsp0v, f_rsp1v;
    logic [AW-1:0] f_a0, f_a1, f_rom_addr, f_rom_reg;
    logic [DW-1:0] f_rsp0d, f_rsp1d, f_rom_data;

    rom_fetch_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
        .clock(clock), .reset(f_reset),
        .req0_valid(f_v0), .req0_addr(f_a0), .req0_ready(f_rdy0),
        .rsp0_valid(f_rsp0v), .rsp0_data(f_rsp0d),
        .req1_valid(f_v1), .req1_addr(f_a1), .req1_ready(f_rdy1),
        .rsp1_valid(f_rsp1v), .rsp1_data(f_rsp1d),
        .rom_address(f_rom_addr), .rom_instruction(f_rom_data)
    );

    always @(posedge clock) f_rom_reg <= f_rom_addr;
    assign f_rom_data = 32'hA000_0000 + DW'(f_rom_reg);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          v0;
        logic [AW-1:0] a0;
        logic          v1;
        logic [AW-1:0] a1;
        logic          rdy0;
        logic          rdy1;
        logic          rsp0v;
        logic [DW-1:0] rsp0d;
        logic          rsp1v;
        logic [DW-1:0] rsp1d;
        logic [AW-1:0] raddr;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(logic rst, logic iv0, logic [AW-1:0] ia0, logic iv1, logic [AW-1:0] ia1,
                                logic e_r0, logic e_r1, logic e_v0, logic [DW-1:0] e_d0,
                                logic e_v1, logic [DW-1:0] e_d1, logic [AW-1:0] e_ra);
        vec_t v;
        v.rst = rst; v.v0 = iv0; v.a0 = ia0; v.v1 = iv1; v.a1 = ia1;
        v.rdy0 = e_r0; v.rdy1 = e_r1; v.rsp0v = e_v0; v.rsp0d = e_d0;
        v.rsp1v = e_v1; v.rsp1d = e_d1; v.raddr = e_ra;
        return v;
    endfunction

    initial begin
        //             rst v0 a0  v1 a1   rdy0 rdy1 r0v r0d            r1v r1d            raddr
        tbl[0]  = mk(1, 1, 5,  1, 2,   0, 0, 0, 32'h0,          0, 32'h0,          0);   // reset gates all
        tbl[1]  = mk(0, 1, 5,  0, 0,   1, 0, 0, 32'h0,          0, 32'h0,          5);   // port 0 alone
        tbl[2]  = mk(0, 0, 0,  0, 0,   0, 0, 1, 32'hA000_0005,  0, 32'h0,          5);
        tbl[3]  = mk(0, 0, 0,  0, 0,   0, 0, 0, 32'h0,          0, 32'h0,          5);
        tbl[4]  = mk(1, 0, 0,  0, 0,   0, 0, 0, 32'h0,          0, 32'h0,          0);   // re-reset prio
        tbl[5]  = mk(0, 1, 1,  1, 2,   1, 0, 0, 32'h0,          0, 32'h0,          1);   // contention
        tbl[6]  = mk(0, 1, 1,  1, 2,   0, 1, 1, 32'hA000_0001,  0, 32'h0,          2);
        tbl[7]  = mk(0, 1, 1,  1, 2,   1, 0, 0, 32'h0,          1, 32'hA000_0002,  1);
        tbl[8]  = mk(0, 1, 1,  1, 2,   0, 1, 1, 32'hA000_0001,  0, 32'h0,          2);
        tbl[9]  = mk(0, 0, 0,  0, 0,   0, 0, 0, 32'h0,          1, 32'hA000_0002,  2);
        tbl[10] = mk(0, 0, 0,  1, 63,  0, 1, 0, 32'h0,          0, 32'h0,          63);  // wrap 63 -> 0
        tbl[11] = mk(0, 0, 0,  1, 0,   0, 1, 0, 32'h0,          1, 32'hA000_003F,  0);
        tbl[12] = mk(0, 0, 0,  0, 0,   0, 0, 0, 32'h0,          1, 32'hA000_0000,  0);
        tbl[13] = mk(0, 1, 7,  0, 0,   1, 0, 0, 32'h0,          0, 32'h0,          7);   // accept then reset
        tbl[14] = mk(1, 0, 0,  0, 0,   0, 0, 0, 32'h0,          0, 32'h0,          0);
        tbl[15] = mk(0, 1, 3,  1, 4,   1, 0, 0, 32'h0,          0, 32'h0,          3);   // prio back at 0
        tbl[16] = mk(0, 0, 0,  0, 0,   0, 0, 1, 32'hA000_0003,  0, 32'h0,          3);
        tbl[17] = mk(0, 0, 0,  1, 9,   0, 1, 0, 32'h0,          0, 32'h0,          9);   // idle hold
        tbl[18] = mk(0, 0, 0,  0, 0,   0, 0, 0, 32'h0,          1, 32'hA000_0009,  9);
        tbl[19] = mk(0, 0, 0,  0, 0,   0, 0, 0, 32'h0,          0, 32'h0,          9);
        tbl[20] = mk(0, 1, 12, 1, 12,  1, 0, 0, 32'h0,          0, 32'h0,          12);  // same address
        tbl[21] = mk(0, 1, 12, 1, 12,  0, 1, 1, 32'hA000_000C,  0, 32'h0,          12);
        tbl[22] = mk(0, 0, 0,  0, 0,   0, 0, 0, 32'h0,          1, 32'hA000_000C,  12);

        f_reset = 1'b1; f_v0 = 1'b0; f_v1 = 1'b0; f_a0 = '0; f_a1 = '0;

        for (int i = 0; i < 23; i++) begin
            @(posedge clock); #1;
            reset = tbl[i].rst; v0 = tbl[i].v0; a0 = tbl[i].a0; v1 = tbl[i].v1; a1 = tbl[i].a1;
            @(negedge clock);
            check($sformatf("v%0d_rdy0", i),  32'(rdy0),     32'(tbl[i].rdy0));
            check($sformatf("v%0d_rdy1", i),  32'(rdy1),     32'(tbl[i].rdy1));
            check($sformatf("v%0d_rsp0v", i), 32'(rsp0v),    32'(tbl[i].rsp0v));
            check($sformatf("v%0d_rsp0d", i), rsp0d,         tbl[i].rsp0d);
            check($sformatf("v%0d_rsp1v", i), 32'(rsp1v),    32'(tbl[i].rsp1v));
            check($sformatf("v%0d_rsp1d", i), rsp1d,         tbl[i].rsp1d);
            check($sformatf("v%0d_romaddr", i), 32'(rom_addr), 32'(tbl[i].raddr));
        end

        // Fixed-priority contention: port 0 wins every cycle, port 1 starves.
        @(posedge clock); #1;
        f_reset = 1'b1;
        @(posedge clock); #1;
        f_reset = 1'b0; f_v0 = 1'b1; f_a0 = 6'd1; f_v1 = 1'b1; f_a1 = 6'd2;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check($sformatf("fp%0d_rdy0", c),  32'(f_rdy0),  32'd1);
            check($sformatf("fp%0d_rdy1", c),  32'(f_rdy1),  32'd0);
            check($sformatf("fp%0d_rsp1v", c), 32'(f_rsp1v), 32'd0);
            check($sformatf("fp%0d_romaddr", c), 32'(f_rom_addr), 32'd1);
            check($sformatf("fp%0d_rsp0v", c), 32'(f_rsp0v), (c == 0) ? 32'd0 : 32'd1);
            check($sformatf("fp%0d_rsp0d", c), f_rsp0d, (c == 0) ? 32'h0 : 32'hA000_0001);
            @(posedge clock); #1;
        end
        f_v0 = 1'b0; f_v1 = 1'b0;
        @(negedge clock);
        check("fp_tail_rsp0v", 32'(f_rsp0v), 32'd1);
        check("fp_tail_rsp0d", f_rsp0d, 32'hA000_0001);
        check("fp_tail_rsp1v", 32'(f_rsp1v), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("fp_idle_rsp0v", 32'(f_rsp0v), 32'd0);
        check("fp_idle_romaddr", 32'(f_rom_addr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rom_fetch_arbiter
